// File: rtl/stopwatch_lap_core.sv
// Stopwatch/countdown core with lap memory, alarm blinker and paused-display blinker.
// Define LAP_OVERWRITE_EN to make the lap memory a circular buffer that overwrites the oldest lap.
module stopwatch_lap_core #(
  parameter  int HOUR_MAX   = 24,
  parameter  int LAP_DEPTH  = 8,
  parameter  int ALARM_HALF = 50,
  parameter  int DISP_HALF  = 25,
  localparam int LAP_AW     = $clog2(LAP_DEPTH)
) (
  input  logic              clk_100Hz,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              lap,
  input  logic              clr,
  input  logic              min_inc,
  input  logic              hour_inc,
  input  logic              countdown_mode,
  input  logic              recall_en,
  input  logic [LAP_AW-1:0] recall_sel,
  output logic [7:0]        hours,
  output logic [7:0]        minutes,
  output logic [7:0]        seconds,
  output logic [7:0]        centisec,
  output logic [LAP_AW:0]   lap_count,
  output logic              lap_full,
  output logic              running,
  output logic              stopped,
  output logic              alarm,
  output logic              blink_phase
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int ADW = $clog2(ALARM_HALF + 1);
  localparam int DDW = $clog2(DISP_HALF + 1);
  localparam logic [7:0]      HOUR_LAST = 8'(HOUR_MAX - 1);
  localparam logic [LAP_AW:0] LAP_MAXC  = (LAP_AW + 1)'(LAP_DEPTH);

  logic [5:0] btn, btn_d, pls;
  logic start_p, stop_p, lap_p, clr_p, min_p, hour_p;

  logic [1:0] state_q, state_n;
  logic [7:0] h_q, m_q, s_q, c_q;
  logic [7:0] h_n, m_n, s_n, c_n;
  logic       time_zero, lap_we;

  logic [31:0]       lap_mem [LAP_DEPTH];
  logic [LAP_AW-1:0] wr_ptr, rd_idx;
  logic [31:0]       rec_val;

  logic [ADW-1:0] alarm_div;
  logic [DDW-1:0] blink_div;

  assign btn = {start, stop, lap, clr, min_inc, hour_inc};
  assign pls = btn & ~btn_d;
  assign {start_p, stop_p, lap_p, clr_p, min_p, hour_p} = pls;

  assign running  = (state_q == S_RUN);
  assign stopped  = (state_q == S_PAUSE);
  assign lap_full = (lap_count == LAP_MAXC);

  always_comb begin
    state_n   = state_q;
    h_n       = h_q;
    m_n       = m_q;
    s_n       = s_q;
    c_n       = c_q;
    lap_we    = 1'b0;
    time_zero = ({h_q, m_q, s_q, c_q} == '0);
    if (clr_p) begin
      state_n = S_IDLE;
      h_n = '0;
      m_n = '0;
      s_n = '0;
      c_n = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_p && !stop_p && !(countdown_mode && time_zero)) state_n = S_RUN;
        end
        S_RUN: begin
          lap_we = lap_p;
          if (!countdown_mode) begin
            if (c_q != 8'd99) c_n = c_q + 8'd1;
            else begin
              c_n = '0;
              if (s_q != 8'd59) s_n = s_q + 8'd1;
              else begin
                s_n = '0;
                if (m_q != 8'd59) m_n = m_q + 8'd1;
                else begin
                  m_n = '0;
                  h_n = (h_q == HOUR_LAST) ? '0 : h_q + 8'd1;
                end
              end
            end
          end else if (!time_zero) begin
            if (c_q != 8'd0) c_n = c_q - 8'd1;
            else begin
              c_n = 8'd99;
              if (s_q != 8'd0) s_n = s_q - 8'd1;
              else begin
                s_n = 8'd59;
                if (m_q != 8'd0) m_n = m_q - 8'd1;
                else begin
                  m_n = 8'd59;
                  h_n = h_q - 8'd1;
                end
              end
            end
          end
          // Reaching zero wins over a simultaneous stop.
          if (countdown_mode && ({h_n, m_n, s_n, c_n} == '0)) state_n = S_DONE;
          else if (stop_p) state_n = S_PAUSE;
        end
        S_PAUSE: begin
          lap_we = lap_p;
          if (start_p && !stop_p) state_n = S_RUN;
        end
        default: ;
      endcase
      if (state_q == S_IDLE || state_q == S_PAUSE) begin
        if (min_p)  m_n = (m_q == 8'd59) ? '0 : m_q + 8'd1;
        if (hour_p) h_n = (h_q == HOUR_LAST) ? '0 : h_q + 8'd1;
      end
`ifndef LAP_OVERWRITE_EN
      if (lap_full) lap_we = 1'b0;
`endif
    end
  end

  always_comb begin
`ifdef LAP_OVERWRITE_EN
    rd_idx = lap_full ? (wr_ptr + recall_sel) : recall_sel;
`else
    rd_idx = recall_sel;
`endif
    rec_val = ({1'b0, recall_sel} < lap_count) ? lap_mem[rd_idx] : '0;
  end

  always_ff @(posedge clk_100Hz or posedge rst) begin
    if (rst) begin
      btn_d     <= '0;
      state_q   <= S_IDLE;
      h_q       <= '0;
      m_q       <= '0;
      s_q       <= '0;
      c_q       <= '0;
      hours     <= '0;
      minutes   <= '0;
      seconds   <= '0;
      centisec  <= '0;
      wr_ptr    <= '0;
      lap_count <= '0;
      for (int unsigned i = 0; i < LAP_DEPTH; i++) lap_mem[i] <= '0;
    end else begin
      btn_d   <= btn;
      state_q <= state_n;
      {h_q, m_q, s_q, c_q} <= {h_n, m_n, s_n, c_n};
      {hours, minutes, seconds, centisec} <= recall_en ? rec_val : {h_n, m_n, s_n, c_n};
      if (clr_p) begin
        wr_ptr    <= '0;
        lap_count <= '0;
        for (int unsigned i = 0; i < LAP_DEPTH; i++) lap_mem[i] <= '0;
      end else if (lap_we) begin
        lap_mem[wr_ptr] <= {h_q, m_q, s_q, c_q};
        wr_ptr          <= wr_ptr + 1'b1;
        if (!lap_full) lap_count <= lap_count + 1'b1;
      end
    end
  end

  // Dividers only run while the state holds; entry and exit edges restart them.
  always_ff @(posedge clk_100Hz or posedge rst) begin
    if (rst) begin
      alarm_div   <= '0;
      alarm       <= 1'b0;
      blink_div   <= '0;
      blink_phase <= 1'b1;
    end else begin
      if (state_q == S_DONE && state_n == S_DONE) begin
        if (alarm_div == ADW'(ALARM_HALF - 1)) begin
          alarm_div <= '0;
          alarm     <= ~alarm;
        end else begin
          alarm_div <= alarm_div + 1'b1;
        end
      end else begin
        alarm_div <= '0;
        alarm     <= 1'b0;
      end
      if (state_q == S_PAUSE && state_n == S_PAUSE) begin
        if (blink_div == DDW'(DISP_HALF - 1)) begin
          blink_div   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_div <= blink_div + 1'b1;
        end
      end else begin
        blink_div   <= '0;
        blink_phase <= 1'b1;
      end
    end
  end

endmodule
